// File: rtl/pipe_mux_pkg.sv
// Shared pipeline-stage definitions: skid-stage state encoding, default
// word geometry and the word record carried through a stage register.
package pipe_mux_pkg;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_N     = 2;
    localparam int PIPE_SELW  = $clog2(PIPE_N);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [PIPE_WIDTH-1:0] data;
        logic [PIPE_SELW-1:0]  sel;
        logic                  err;
    } pipe_word_t;

    function automatic logic is_pow2(input int n);
        return (n > 32'sd0) && ((n & (n - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/pipe_mux_mux_sel_n.sv
// Combinational N:1 word selector; a select with no matching input yields
// a zero word and raises err.
module mux_sel_n
    import pipe_mux_pkg::*;
#(
    parameter  int WIDTH = PIPE_WIDTH,
    parameter  int N     = PIPE_N,
    localparam int SELW  = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [SELW-1:0]    i_sel,
    output logic [WIDTH-1:0]   o_word,
    output logic               o_err
);

    // AND-OR select: no input matches an out-of-range select, so the word is zero
    always_comb begin
        o_word = '0;
        for (int k = 0; k < N; k++) begin
            o_word = o_word | (i_data[k*WIDTH +: WIDTH] & {WIDTH{i_sel == SELW'(k)}});
        end
    end

    if (is_pow2(N)) begin : g_pow2
        assign o_err = 1'b0;
    end else begin : g_range
        assign o_err = (i_sel >= SELW'(N));
    end

endmodule

// File: rtl/pipe_mux.sv
// Registered N:1 word selector with valid/ready handshake, two-entry skid
// storage and synchronous flush; outputs come straight from registers.
module pipe_mux
    import pipe_mux_pkg::*;
#(
    parameter  int WIDTH = PIPE_WIDTH,
    parameter  int N     = PIPE_N,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  sel;
        logic             err;
    } word_t;

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    word_t            r_main;
    word_t            r_skid;
    word_t            w_main_nxt;
    word_t            w_skid_nxt;
    word_t            w_new;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] w_mux_word;
    logic             w_mux_err;
    logic             w_accept;
    logic             w_pop;

    mux_sel_n #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_mux (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_word (w_mux_word),
        .o_err  (w_mux_err)
    );

    assign w_new    = '{data: w_mux_word, sel: in_sel, err: w_mux_err};
    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;

    // Next-state and storage update; flush overrides any accept or pop
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_new;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_new;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = w_new;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end else begin
                        w_state_nxt = ST_TWO;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main and skid word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            r_main <= w_main_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    // Handshake flags registered from next state, so in_ready never sees out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main.data;
    assign out_sel   = r_main.sel;
    assign out_err   = r_main.err;

endmodule

// File: tb/tb_pipe_mux.sv
// Directed bench for pipe_mux: a 4-input instance for handshake behaviour
// and a 3-input instance for the out-of-range select.
module tb_pipe_mux;

    logic         clk;
    logic         rst_n;

    logic [127:0] d4;
    logic [1:0]   s4;
    logic         v4, f4, or4;
    logic         ir4, oe4, ov4;
    logic [31:0]  od4;
    logic [1:0]   os4;

    logic [95:0]  d3;
    logic [1:0]   s3;
    logic         v3, f3, or3;
    logic         ir3, oe3, ov3;
    logic [31:0]  od3;
    logic [1:0]   os3;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic        acc;
    logic        pop;

    localparam logic [31:0] WA = 32'hAAAA_0000;
    localparam logic [31:0] WB = 32'hBBBB_0000;

    pipe_mux #(.WIDTH(32), .N(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d4),
        .in_sel    (s4),
        .in_valid  (v4),
        .in_ready  (ir4),
        .flush     (f4),
        .out_data  (od4),
        .out_sel   (os4),
        .out_err   (oe4),
        .out_valid (ov4),
        .out_ready (or4)
    );

    pipe_mux #(.WIDTH(32), .N(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d3),
        .in_sel    (s3),
        .in_valid  (v3),
        .in_ready  (ir3),
        .flush     (f3),
        .out_data  (od3),
        .out_sel   (os3),
        .out_err   (oe3),
        .out_valid (ov3),
        .out_ready (or3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d4 = '0; s4 = 2'd0; v4 = 1'b0; f4 = 1'b0; or4 = 1'b1;
        d3 = '0; s3 = 2'd0; v3 = 1'b0; f3 = 1'b0; or3 = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(ov4), 64'd0);
        chk("rst_ready", 64'(ir4), 64'd1);
        chk("rst_data",  64'(od4), 64'd0);
        chk("rst_sel",   64'(os4), 64'd0);
        chk("rst_err",   64'(oe4), 64'd0);
        rst_n = 1'b1;
        tick();

        // streaming: one word per cycle, each visible right after its accept edge
        d4  = {32'h44, 32'h33, 32'h22, 32'h11};
        v4  = 1'b1;
        or4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s4 = 2'(k);
            tick();
            exp_w = 32'h11 * 32'(k + 1);
            chk("stream_valid", 64'(ov4), 64'd1);
            chk("stream_data",  64'(od4), 64'(exp_w));
            chk("stream_sel",   64'(os4), 64'(k));
            chk("stream_ready", 64'(ir4), 64'd1);
        end
        chk("stream_err_pow2", 64'(oe4), 64'd0);
        v4 = 1'b0;
        tick();
        chk("stream_drain", 64'(ov4), 64'd0);

        // back-pressure: fill both entries, then release
        or4 = 1'b0;
        v4  = 1'b1;
        s4  = 2'd0;
        d4  = {96'd0, WA};
        tick();
        chk("bp_a_valid", 64'(ov4), 64'd1);
        chk("bp_a_data",  64'(od4), 64'(WA));
        chk("bp_a_ready", 64'(ir4), 64'd1);
        d4 = {96'd0, WB};
        tick();
        chk("bp_b_ready", 64'(ir4), 64'd0);
        chk("bp_b_hold",  64'(od4), 64'(WA));
        v4 = 1'b0;
        tick();
        chk("bp_stall_data",  64'(od4), 64'(WA));
        chk("bp_stall_ready", 64'(ir4), 64'd0);
        chk("bp_stall_valid", 64'(ov4), 64'd1);
        or4 = 1'b1;
        tick();
        chk("bp_pop1_data",  64'(od4), 64'(WB));
        chk("bp_pop1_ready", 64'(ir4), 64'd1);
        chk("bp_pop1_valid", 64'(ov4), 64'd1);
        tick();
        chk("bp_pop2_valid", 64'(ov4), 64'd0);
        chk("bp_pop2_ready", 64'(ir4), 64'd1);

        // flush from TWO with an offer and a pop in the same cycle
        or4 = 1'b0;
        v4  = 1'b1;
        d4  = {96'd0, WA};
        tick();
        d4 = {96'd0, WB};
        tick();
        chk("fl_two_ready", 64'(ir4), 64'd0);
        f4  = 1'b1;
        d4  = {96'd0, 32'h5};
        or4 = 1'b1;
        tick();
        chk("fl_two_valid", 64'(ov4), 64'd0);
        chk("fl_two_ready_after", 64'(ir4), 64'd1);
        f4 = 1'b0;
        v4 = 1'b0;
        tick();
        chk("fl_two_stay_empty", 64'(ov4), 64'd0);

        // flush from ONE while a word is offered and acceptable
        or4 = 1'b0;
        v4  = 1'b1;
        d4  = {96'd0, WA};
        tick();
        chk("fl_one_valid", 64'(ov4), 64'd1);
        f4 = 1'b1;
        d4 = {96'd0, 32'h5};
        tick();
        chk("fl_one_dropped", 64'(ov4), 64'd0);
        f4 = 1'b0;
        v4 = 1'b0;
        tick();
        chk("fl_one_no_5", 64'(ov4), 64'd0);

        // out-of-range select on the 3-input instance
        d3  = {3{32'hFFFF_FFFF}};
        s3  = 2'd3;
        v3  = 1'b1;
        or3 = 1'b1;
        tick();
        chk("oor_valid", 64'(ov3), 64'd1);
        chk("oor_data",  64'(od3), 64'd0);
        chk("oor_err",   64'(oe3), 64'd1);
        chk("oor_sel",   64'(os3), 64'd3);
        s3 = 2'd2;
        tick();
        chk("inr_data", 64'(od3), 64'hFFFF_FFFF);
        chk("inr_err",  64'(oe3), 64'd0);
        v3 = 1'b0;
        tick();
        chk("oor_drain", 64'(ov3), 64'd0);

        // asynchronous reset with two words held, checked between clock edges
        or4 = 1'b0;
        v4  = 1'b1;
        d4  = {96'd0, WA};
        tick();
        d4 = {96'd0, WB};
        tick();
        v4 = 1'b0;
        chk("arst_pre_ready", 64'(ir4), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ov4), 64'd0);
        chk("arst_ready", 64'(ir4), 64'd1);
        chk("arst_data",  64'(od4), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // random handshake traffic against a queue model
        q.delete();
        for (int i = 0; i < 2000; i++) begin
            v4  = 1'($urandom_range(0, 1));
            or4 = ($urandom_range(0, 3) != 0);
            f4  = ($urandom_range(0, 31) == 0);
            s4  = 2'($urandom_range(0, 3));
            d4  = {$urandom(), $urandom(), $urandom(), $urandom()};
            acc = v4 && (q.size() < 2);
            pop = (q.size() != 0) && or4;
            tick();
            if (f4) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(d4[s4*32 +: 32]);
            end
            chk("rnd_valid", 64'(ov4), 64'(q.size() != 0));
            chk("rnd_ready", 64'(ir4), 64'(q.size() < 2));
            if (q.size() != 0) chk("rnd_data", 64'(od4), 64'(q[0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
